ps_reg_slave: RTL and testbench

PS_REG_SLAVE -- requirements
Module: ps_reg_slave

---
 rtl/ps_reg_slave.sv | 160 ++++++++++++++++
 tb/tb_ps_reg_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_reg_slave.sv
// ps_reg_slave: parameterised register bank with a write channel
// (always ready, one-cycle write response) and a read channel with
// one-cycle latency, back-pressure through rready, and a single-entry
// pending buffer for read requests that arrive while a response is stalled.
//
// Read FSM
//   state  | meaning
//   S_IDLE | no response outstanding, rvalid = 0
//   S_RESP | response presented on rdata, rvalid = 1, waiting for rready
module ps_reg_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // write channel
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           wresp,
  // read channel
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           arvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           rready,
  // register contents and status
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic                           drop_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } rd_state_e;

  logic [DATA_WIDTH-1:0] regs_mem_q [NUM_REGS];
  logic                  wready_q;
  logic                  wresp_q;
  logic                  wr_acc;

  rd_state_e             state_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  pend_vld_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  drop_err_q;

  logic [DATA_WIDTH-1:0] raddr_data;
  logic [DATA_WIDTH-1:0] pend_data;

  assign wr_acc = wvalid && wready_q;

  // wready is held low during reset and rises on the first cycle after it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wready_q <= 1'b0;
    end else begin
      wready_q <= 1'b1;
    end
  end

  // every accepted write, legal address or not, is acknowledged one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wresp_q <= 1'b0;
    end else begin
      wresp_q <= wr_acc;
    end
  end

  // register bank; addresses at or beyond NUM_REGS match no entry and are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr == ADDR_WIDTH'(i)) begin
          regs_mem_q[i] <= wdata;
        end
      end
    end
  end

  // read muxes on the pre-write register values; unimplemented addresses read 0
  always_comb begin
    raddr_data = '0;
    pend_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        raddr_data = regs_mem_q[i];
      end
      if (pend_addr_q == ADDR_WIDTH'(i)) begin
        pend_data = regs_mem_q[i];
      end
    end
  end

  // read FSM: data is captured when a response launches and held while stalled;
  // a pending request is always served ahead of a new one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdata_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arvalid) begin
            rdata_q <= raddr_data;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rready) begin
            if (pend_vld_q) begin
              rdata_q <= pend_data;
              if (arvalid) begin
                pend_addr_q <= raddr;
              end else begin
                pend_vld_q <= 1'b0;
              end
            end else if (arvalid) begin
              rdata_q <= raddr_data;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (arvalid) begin
            if (!pend_vld_q) begin
              pend_vld_q  <= 1'b1;
              pend_addr_q <= raddr;
            end else begin
              drop_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // flatten the bank onto the regs_q output, register i at [i*DATA_WIDTH +: DATA_WIDTH]
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_mem_q[g];
  end

  assign wready   = wready_q;
  assign wresp    = wresp_q;
  assign rdata    = rdata_q;
  assign rvalid   = (state_q == S_RESP);
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_ps_reg_slave.sv
// Directed bench for ps_reg_slave: reset state, writes, illegal addresses,
// stalled reads with the pending buffer, overflow, write/read collision and
// reset while a response is outstanding.
module tb_ps_reg_slave;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          wresp;
  logic [AW-1:0] raddr;
  logic          arvalid;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic [NR*DW-1:0] regs_q;
  logic          drop_err;

  logic [DW-1:0] exp_regs [NR];
  int            pass_cnt;
  int            total_cnt;

  ps_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .waddr    (waddr),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .wresp    (wresp),
    .raddr    (raddr),
    .arvalid  (arvalid),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .regs_q   (regs_q),
    .drop_err (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    tick(); tick();
    total_cnt++;
    if (wready !== 1'b0) $display("FAIL reset_wready got %0b want 0", wready); else pass_cnt++;
    total_cnt++;
    if ({rvalid, wresp, drop_err} !== 3'b000)
      $display("FAIL reset_flags got rvalid/wresp/drop_err=%03b want 000", {rvalid, wresp, drop_err});
    else pass_cnt++;
    total_cnt++;
    if (rdata !== '0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
    total_cnt++;
    if (regs_q !== exp_flat()) $display("FAIL reset_regs got %h want 0", regs_q); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (wready !== 1'b1) $display("FAIL wready_after_reset got %0b want 1", wready); else pass_cnt++;
  endtask

  task automatic test_write_read();
    waddr = 5'd3; wdata = 32'hDEADBEEF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    exp_regs[3] = 32'hDEADBEEF;
    total_cnt++;
    if (wresp !== 1'b1) $display("FAIL write_wresp got %0b want 1", wresp); else pass_cnt++;
    total_cnt++;
    if (regs_q[3*DW +: DW] !== 32'hDEADBEEF)
      $display("FAIL write_reg3 got %h want deadbeef", regs_q[3*DW +: DW]);
    else pass_cnt++;
    raddr = 5'd3; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (wresp !== 1'b0) $display("FAIL write_wresp_single got %0b want 0", wresp); else pass_cnt++;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF)
      $display("FAIL read_reg3 got rvalid=%0b rdata=%h want 1 deadbeef", rvalid, rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL read_return_idle got %0b want 0", rvalid); else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_illegal_addr();
    waddr = 5'd20; wdata = 32'h12345678; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total_cnt++;
    if (wresp !== 1'b1) $display("FAIL illegal_wresp got %0b want 1", wresp); else pass_cnt++;
    total_cnt++;
    if (regs_q !== exp_flat()) $display("FAIL illegal_regs got %h want %h", regs_q, exp_flat()); else pass_cnt++;
    raddr = 5'd20; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h0)
      $display("FAIL illegal_read got rvalid=%0b rdata=%h want 1 0", rvalid, rdata);
    else pass_cnt++;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    waddr = 5'd1; wdata = 32'h11111111; wvalid = 1'b1;
    tick();
    exp_regs[1] = 32'h11111111;
    total_cnt++;
    if (wresp !== 1'b1) $display("FAIL b2b_wresp1 got %0b want 1", wresp); else pass_cnt++;
    waddr = 5'd2; wdata = 32'h22222222;
    tick();
    exp_regs[2] = 32'h22222222;
    wvalid = 1'b0;
    total_cnt++;
    if (wresp !== 1'b1) $display("FAIL b2b_wresp2 got %0b want 1", wresp); else pass_cnt++;
    tick();
    total_cnt++;
    if (wresp !== 1'b0) $display("FAIL b2b_wresp_end got %0b want 0", wresp); else pass_cnt++;
    total_cnt++;
    if (regs_q !== exp_flat()) $display("FAIL b2b_regs got %h want %h", regs_q, exp_flat()); else pass_cnt++;
  endtask

  task automatic test_stall();
    rready = 1'b0; raddr = 5'd1; arvalid = 1'b1;
    tick();
    raddr = 5'd2;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h11111111)
      $display("FAIL stall_first got rvalid=%0b rdata=%h want 1 11111111", rvalid, rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h11111111)
      $display("FAIL stall_hold got rvalid=%0b rdata=%h want 1 11111111", rvalid, rdata);
    else pass_cnt++;
    rready = 1'b1;
    tick();
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h22222222)
      $display("FAIL stall_pending got rvalid=%0b rdata=%h want 1 22222222", rvalid, rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0 || drop_err !== 1'b0)
      $display("FAIL stall_end got rvalid=%0b drop_err=%0b want 0 0", rvalid, drop_err);
    else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_refill();
    rready = 1'b0; raddr = 5'd1; arvalid = 1'b1;
    tick();
    raddr = 5'd2;
    tick();
    raddr = 5'd3; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rdata !== 32'h22222222) $display("FAIL refill_pending got %h want 22222222", rdata); else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF)
      $display("FAIL refill_second got rvalid=%0b rdata=%h want 1 deadbeef", rvalid, rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0 || drop_err !== 1'b0)
      $display("FAIL refill_end got rvalid=%0b drop_err=%0b want 0 0", rvalid, drop_err);
    else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_same_cycle();
    waddr = 5'd0; wdata = 32'h5; wvalid = 1'b1;
    raddr = 5'd0; arvalid = 1'b1; rready = 1'b1;
    tick();
    wvalid = 1'b0;
    exp_regs[0] = 32'h5;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h0)
      $display("FAIL collide_old got rvalid=%0b rdata=%h want 1 0", rvalid, rdata);
    else pass_cnt++;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== 32'h5)
      $display("FAIL collide_new got rvalid=%0b rdata=%h want 1 5", rvalid, rdata);
    else pass_cnt++;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_overflow();
    rready = 1'b0; raddr = 5'd1; arvalid = 1'b1;
    tick();
    raddr = 5'd2;
    tick();
    total_cnt++;
    if (drop_err !== 1'b0) $display("FAIL ovf_before got %0b want 0", drop_err); else pass_cnt++;
    raddr = 5'd3;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (drop_err !== 1'b1 || rdata !== 32'h11111111)
      $display("FAIL ovf_drop got drop_err=%0b rdata=%h want 1 11111111", drop_err, rdata);
    else pass_cnt++;
    rready = 1'b1;
    tick();
    total_cnt++;
    if (rdata !== 32'h22222222) $display("FAIL ovf_pending got %h want 22222222", rdata); else pass_cnt++;
    tick();
    total_cnt++;
    if (rvalid !== 1'b0 || drop_err !== 1'b1)
      $display("FAIL ovf_sticky got rvalid=%0b drop_err=%0b want 0 1", rvalid, drop_err);
    else pass_cnt++;
    rready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    raddr = 5'd3; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1) $display("FAIL inflight_rvalid got %0b want 1", rvalid); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    total_cnt++;
    if (rvalid !== 1'b0 || drop_err !== 1'b0 || wready !== 1'b0 || rdata !== '0)
      $display("FAIL inflight_reset got rvalid=%0b drop_err=%0b wready=%0b rdata=%h want 0 0 0 0",
               rvalid, drop_err, wready, rdata);
    else pass_cnt++;
    total_cnt++;
    if (regs_q !== exp_flat()) $display("FAIL inflight_regs got %h want 0", regs_q); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (wready !== 1'b1 || rvalid !== 1'b0)
      $display("FAIL inflight_recover got wready=%0b rvalid=%0b want 1 0", wready, rvalid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_write_read();
    test_illegal_addr();
    test_back_to_back();
    test_stall();
    test_refill();
    test_same_cycle();
    test_overflow();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
